// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default geometry and counter-width helper for sync_fifo
package sync_fifo_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer bundle of sync_fifo; master drives requests, slave is the fifo
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic [WIDTH-1:0] buf_in;
  logic [WIDTH-1:0] buf_out;
  logic wr_en;
  logic rd_en;
  logic buf_empty;
  logic buf_full;
  logic [cnt_w(DEPTH)-1:0] fifo_counter;
  modport master(output buf_in, wr_en, rd_en, input buf_out, buf_empty, buf_full, fifo_counter);
  modport slave(input buf_in, wr_en, rd_en, output buf_out, buf_empty, buf_full, fifo_counter);
endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x WIDTH storage, synchronous write, registered read that clears on rst
module sync_fifo_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic re,
  input  logic [AW-1:0] wa,
  input  logic [AW-1:0] ra,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd
);
  logic [WIDTH-1:0] mem [DEPTH];
  // Storage is deliberately unreset so it maps onto plain RAM.
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, full/empty flags and occupancy count
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic clk,
  input logic rst,
  sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic wr_acc, rd_acc;
  assign bus.buf_empty = cnt == '0;
  assign bus.buf_full = cnt == CNT_W'(DEPTH);
  assign bus.fifo_counter = cnt;
  assign wr_acc = bus.wr_en & ~bus.buf_full;
  assign rd_acc = bus.rd_en & ~bus.buf_empty;
  // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      cnt <= (wr_acc & ~rd_acc) ? cnt + CNT_W'(1) : (rd_acc & ~wr_acc) ? cnt - CNT_W'(1) : cnt;
    end
  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(wr_acc),
    .re(rd_acc),
    .wa(wr_ptr),
    .ra(rd_ptr),
    .wd(bus.buf_in),
    .rd(bus.buf_out)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: queue-model scoreboard bench for sync_fifo with directed cases and a random soak
module tb_sync_fifo;
  localparam int W = 4;
  localparam int D = 8;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  bit done = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_out = '0;
  sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus();
  sync_fifo #(.WIDTH(W), .DEPTH(D)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // Reference model: the fifo as a bounded queue; a read yields the head one edge later.
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      sb.delete();
      exp_out <= '0;
    end else begin
      automatic bit ra = bus.rd_en && q.size() > 0;
      automatic bit wa = bus.wr_en && q.size() < D;
      if (ra) begin
        exp_out <= q[0];
        sb.push_back(q[0]);
        q.delete(0);
      end
      if (wa) q.push_back(bus.buf_in);
    end
  always @(negedge clk)
    if (!rst) begin
      chk("count", int'(bus.fifo_counter), q.size());
      chk("empty", int'(bus.buf_empty), int'(q.size() == 0));
      chk("full", int'(bus.buf_full), int'(q.size() == D));
      chk("hold", int'(bus.buf_out), int'(exp_out));
      if (sb.size() > 0) chk("data", int'(bus.buf_out), int'(sb.pop_front()));
    end
  task automatic cyc(input bit w, input bit r, input int d);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.buf_in = W'(d);
    @(negedge clk);
    bus.wr_en = 0;
    bus.rd_en = 0;
  endtask
  initial begin
    bus.wr_en = 0;
    bus.rd_en = 0;
    bus.buf_in = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_count", int'(bus.fifo_counter), 0);
    chk("rst_empty", int'(bus.buf_empty), 1);
    chk("rst_full", int'(bus.buf_full), 0);
    chk("rst_out", int'(bus.buf_out), 0);
    for (int i = 1; i <= 4; i++) cyc(1, 0, i);
    cyc(0, 1, 0);
    chk("pre_rst_out", int'(bus.buf_out), 1);
    chk("pre_rst_count", int'(bus.fifo_counter), 3);
    #2 rst = 1;
    #1;
    chk("arst_count", int'(bus.fifo_counter), 0);
    chk("arst_empty", int'(bus.buf_empty), 1);
    chk("arst_full", int'(bus.buf_full), 0);
    chk("arst_out", int'(bus.buf_out), 0);
    rst = 0;
    @(negedge clk);
    cyc(1, 0, 5);
    cyc(0, 1, 0);
    chk("post_rst_out", int'(bus.buf_out), 5);
    for (int i = 1; i <= 8; i++) cyc(1, 0, i);
    chk("fill_full", int'(bus.buf_full), 1);
    chk("fill_count", int'(bus.fifo_counter), 8);
    cyc(1, 0, 9);
    chk("drop_count", int'(bus.fifo_counter), 8);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0);
      chk("drain_out", int'(bus.buf_out), i);
    end
    chk("drain_empty", int'(bus.buf_empty), 1);
    chk("drain_count", int'(bus.fifo_counter), 0);
    cyc(0, 1, 0);
    chk("rd_empty_out", int'(bus.buf_out), 8);
    chk("rd_empty_count", int'(bus.fifo_counter), 0);
    for (int i = 1; i <= 3; i++) cyc(1, 0, i);
    cyc(1, 1, 4);
    chk("rw_count", int'(bus.fifo_counter), 3);
    chk("rw_out", int'(bus.buf_out), 1);
    for (int i = 2; i <= 4; i++) begin
      cyc(0, 1, 0);
      chk("rw_drain", int'(bus.buf_out), i);
    end
    cyc(1, 1, 7);
    chk("rw_empty_count", int'(bus.fifo_counter), 1);
    chk("rw_empty_out", int'(bus.buf_out), 4);
    for (int i = 8; i <= 14; i++) cyc(1, 0, i);
    chk("rw_full_pre", int'(bus.buf_full), 1);
    cyc(1, 1, 15);
    chk("rw_full_count", int'(bus.fifo_counter), 7);
    chk("rw_full_out", int'(bus.buf_out), 7);
    for (int i = 8; i <= 14; i++) begin
      cyc(0, 1, 0);
      chk("rw_full_drain", int'(bus.buf_out), i);
    end
    chk("rw_full_empty", int'(bus.buf_empty), 1);
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          bus.wr_en = 1;
          bus.buf_in = W'(i);
          @(negedge clk);
          bus.wr_en = 0;
          repeat ($urandom_range(0, 9)) @(negedge clk);
        end
        done = 1;
      end
      begin
        int n = 0;
        while (!(done && bus.buf_empty) && n < 90000) begin
          bus.rd_en = !bus.buf_empty && $urandom_range(0, 1) == 1;
          @(negedge clk);
          n++;
        end
        bus.rd_en = 0;
        chk("soak_in_budget", int'(n < 90000), 1);
      end
    join
    @(negedge clk);
    chk("soak_empty", int'(bus.buf_empty), 1);
    chk("soak_sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
